adc_share_arbiter: RTL
======================

ADC_SHARE_ARBITER -- requirements
Module: adc_share_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning ADC sample width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum CONV-state cycles to wait for adc_ready.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req0 / req1  input  1 each  level conversion request from capture channel 0 / 1, held until served.
REQ-006 Port: adc_ready  input  1  ADC conversion-done strobe.
REQ-007 Port: adc_data  input  DATA_W  ADC sample, valid while adc_ready=1.
REQ-008 Port: adc_request_out  output  1  request to the shared ADC.
REQ-009 Port: rdy0 / rdy1  output  1 each  one-cycle sample-delivered pulse to channel 0 / 1.
REQ-010 Port: data0 / data1  output  DATA_W each  last sample delivered to channel 0 / 1, held between deliveries.
REQ-011 Port: state  output  2  FSM state: IDLE=0, CONV=1, DELIV=2, GAP=3.
REQ-012 Port: owner  output  1  channel that currently owns or last owned the ADC.
REQ-013 Port: timeout_flag  output  1  sticky, set on any ADC timeout.
REQ-014 Port: err_cnt  output  4  timeout count, saturating.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 IDLE: with neither req high, the FSM SHALL stay in IDLE with adc_request_out=0.
REQ-017 IDLE, one req high: at that edge, owner SHALL take that channel, adc_request_out SHALL go to 1, the timer SHALL clear to 0, and state SHALL go to CONV.
REQ-018 IDLE, both req high: the grant SHALL go to the channel opposite last_grant (round-robin), and last_grant SHALL update to the granted channel.
REQ-019 CONV: adc_request_out SHALL stay 1, and the timer SHALL increment each cycle that adc_ready=0.
REQ-020 CONV with adc_ready=1 sampled: adc_data SHALL be latched into data<owner>, adc_request_out SHALL go to 0, and state SHALL go to DELIV on the same edge.
REQ-021 DELIV: rdy<owner> SHALL be 1 for exactly this one cycle, the other rdy SHALL be 0, and the next state SHALL be GAP.
REQ-022 Withdrawn request (req<owner> low at the adc_ready edge): data<owner> SHALL still be latched, rdy<owner> SHALL NOT pulse, and DELIV SHALL pass with both rdy=0.
REQ-023 GAP: one cycle with adc_request_out=0 (lets the requester drop req); then IDLE unconditionally.
REQ-024 Timeout: in CONV with timer=TIMEOUT-1 and adc_ready=0, adc_request_out SHALL go to 0, timeout_flag SHALL go to 1, err_cnt SHALL increment (saturating at 15), and state SHALL go to GAP with no delivery and data unchanged.
REQ-025 Round-robin SHALL advance on timeout as on success, so a dead conversion does not starve the other channel.
REQ-026 Latency, uncontested: req sampled at edge n gives adc_request_out=1 after edge n; adc_ready sampled at edge k gives rdy=1 for the cycle after edge k; the next grant is no earlier than edge k+3.
REQ-027 adc_ready in IDLE, DELIV or GAP SHALL be ignored: no data latch and no state change.
REQ-028 adc_ready coinciding with the timeout edge SHALL count as success; success takes priority over timeout.
REQ-029 A request arriving in CONV, DELIV or GAP SHALL remain pending by level and be arbitrated at the next IDLE.

Reset
REQ-030 Reset=1 at an edge SHALL force: state=IDLE, adc_request_out=0, rdy0=rdy1=0, data0=data1=0, owner=0, last_grant=1 (so channel 0 wins the first tie), timer=0, timeout_flag=0, err_cnt=0.
REQ-031 Reset mid-CONV or mid-DELIV SHALL abort with no rdy pulse on the following cycle and no data update.
REQ-032 Reset SHALL take priority over every other event at the same edge.

Verification
REQ-033 Single request: req0=1 after reset, adc_ready=1 with adc_data=0xA5 three cycles later -> owner=0, data0=0xA5, rdy0 one-cycle pulse, rdy1 never high, state sequence 1,2,3,0.
REQ-034 Tie: req0=req1=1 held, each conversion answered -> grants alternate 0,1,0,1; neither channel is granted twice in a row.
REQ-035 Timeout: req1=1, adc_ready held 0 -> adc_request_out falls after exactly 16 CONV cycles, timeout_flag=1, err_cnt=1, no rdy1 pulse, data1=0; 16 further timeouts -> err_cnt stays 15.
REQ-036 Boundary: adc_ready=1 exactly on the 16th CONV cycle -> treated as success, timeout_flag stays 0.
REQ-037 Reset mid-CONV: reset at the 2nd CONV cycle, adc_ready=1 in the next cycle -> state=0, adc_request_out=0, no rdy pulse, data unchanged.
REQ-038 Stray ready: adc_ready pulsed in IDLE with 0x3C -> data0 and data1 unchanged, state stays 0.

Source files
------------

// File: rtl/adc_share_arbiter.sv
// Round-robin arbiter sharing one ADC between two capture channels,
// with a per-conversion timeout and sticky/saturating error reporting.
module adc_share_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              adc_ready,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_request_out,
    output logic              rdy0,
    output logic              rdy1,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [1:0]        state,
    output logic              owner,
    output logic              timeout_flag,
    output logic [3:0]        err_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        DELIV = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            st_q, st_d;
    logic              req_out_d, rdy0_d, rdy1_d, owner_d, last_grant_q, last_grant_d;
    logic              flag_d, grant;
    logic [DATA_W-1:0] data0_d, data1_d;
    logic [3:0]        err_d;
    logic [TW-1:0]     timer_q, timer_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q            <= IDLE;
            adc_request_out <= 1'b0;
            rdy0            <= 1'b0;
            rdy1            <= 1'b0;
            data0           <= '0;
            data1           <= '0;
            owner           <= 1'b0;
            last_grant_q    <= 1'b1;
            timer_q         <= '0;
            timeout_flag    <= 1'b0;
            err_cnt         <= '0;
        end else begin
            st_q            <= st_d;
            adc_request_out <= req_out_d;
            rdy0            <= rdy0_d;
            rdy1            <= rdy1_d;
            data0           <= data0_d;
            data1           <= data1_d;
            owner           <= owner_d;
            last_grant_q    <= last_grant_d;
            timer_q         <= timer_d;
            timeout_flag    <= flag_d;
            err_cnt         <= err_d;
        end
    end

    assign state = st_q;

    always_comb begin
        st_d         = st_q;
        req_out_d    = adc_request_out;
        rdy0_d       = 1'b0;
        rdy1_d       = 1'b0;
        data0_d      = data0;
        data1_d      = data1;
        owner_d      = owner;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        flag_d       = timeout_flag;
        err_d        = err_cnt;
        grant        = 1'b0;

        case (st_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant        = (req0 && req1) ? ~last_grant_q : req1;
                    owner_d      = grant;
                    last_grant_d = grant;
                    req_out_d    = 1'b1;
                    timer_d      = '0;
                    st_d         = CONV;
                end
            end
            CONV: begin
                // Success is checked first so a ready on the final cycle wins over timeout.
                if (adc_ready) begin
                    if (owner) begin
                        data1_d = adc_data;
                        rdy1_d  = req1;
                    end else begin
                        data0_d = adc_data;
                        rdy0_d  = req0;
                    end
                    req_out_d = 1'b0;
                    st_d      = DELIV;
                end else if (timer_q == T_LAST) begin
                    req_out_d = 1'b0;
                    flag_d    = 1'b1;
                    err_d     = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;
                    st_d      = GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DELIV:   st_d = GAP;
            default: st_d = IDLE;
        endcase
    end

endmodule
